maze_walker: RTL and testbench
==============================

Name: maze_walker

Overview:
- Produces the final-position inputs (xFin, yFin, alive) that the fitness scorer consumes.
- Executes one genome (a fixed-length sequence of 2-bit moves) on an 8x8 maze bitmap, one move per clock.
- Sits between the genome population store and the fitness scorer in the GA loop.
- Accepts a start pulse, walks, then pulses done with results held stable until the next start.

Parameters:
- N_MOVES, 16, moves per genome; GENOME width = 2*N_MOVES; legal range 1..64.
- MAZE, 64'h0, wall bitmap. Bit index y*8+x; 1 = wall. Bit 0, cell (0,0), must be 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin walk; sampled only in IDLE
- genome  in  2*N_MOVES  move i = genome[2i+1:2i]; move 0 in the LSBs
- xFin  out  4  current/final x, range 0..7
- yFin  out  4  current/final y, range 0..7
- alive  out  1  1 = no illegal move taken
- done  out  1  one-cycle pulse, results valid
- busy  out  1  high in WALK and DONE

Behaviour:
- Reset (async, immediate): state=IDLE; xFin=0, yFin=0, alive=0, done=0, busy=0, step=0, genome register cleared.
- Move encoding: 00 = up (y-1), 01 = right (x+1), 10 = down (y+1), 11 = left (x-1).
- IDLE:
  - start=1 -> latch genome; set pos=(0,0), alive=1, step=0; go to WALK.
  - start=0 -> hold all outputs (previous results persist).
- WALK (one move per cycle, using the latched genome):
  - Compute the target cell from move[step].
  - Illegal move: target off-grid (x or y <0 or >7), or MAZE bit of target = 1. Result: alive<=0, position unchanged, go to DONE.
  - Legal move: position <= target.
  - Then go to DONE if step==N_MOVES-1, or if the goal stop applies (see Optional Feature). Otherwise step <= step+1.
- DONE: done=1 for exactly this cycle, busy=1; next cycle go to IDLE, done=0.
- Latency:
  - Full walk: done asserts N_MOVES+1 rising edges after the edge that sampled start.
  - Early death at move k (0-based): done asserts k+2 edges after that edge.
- xFin/yFin/alive are registered and track the walk live. They are final and stable from the done cycle until the next accepted start.
- Boundary conditions:
  - start during WALK/DONE: ignored; no effect on the walk in progress.
  - genome changes during a walk: no effect (latched copy is used).
  - start high continuously: a new walk starts on the first IDLE cycle after DONE.
  - rst mid-walk: immediate return to reset values; the walk is abandoned and no done pulse is issued.
- Width rules: internal x/y held in 4 bits. Off-grid detection uses 0-1 underflow and 7+1=8 overflow checks before the update. Outputs never show 8 or 15.

Optional Feature:
- Macro: WALKER_GOAL_STOP_EN.
- Defined: entering cell (7,7) on a legal move ends the walk. Next state is DONE, alive=1, remaining moves unused, done latency = k+2 for the goal reached at move k.
- Undefined: the goal has no special meaning; all N_MOVES moves are executed and the walker may leave (7,7).

Test Plan:
- Open maze, N_MOVES=16, genome=32'h5555_5555 (all right). Required: moves 0..6 reach (7,0); move 7 is off-grid; alive=0, xFin=7, yFin=0; done 9 edges after start.
- Open maze, moves 0-6 right, moves 7-13 down, moves 14-15 left:
  - With WALKER_GOAL_STOP_EN: alive=1, (7,7), done 15 edges after start.
  - Without it: alive=1, (5,7), done 17 edges after start.
- MAZE=64'h2 (wall at (1,0)), move 0 = right. Required: alive=0, (0,0), done 2 edges after start.
- genome=0 (move 0 = up) on an open maze. Required: alive=0, (0,0), done 2 edges after start; busy high for 2 cycles.
- During a walk, pulse start and change genome. Required: results match the originally latched genome; exactly one done pulse.
- Assert rst at step 5 of a walk. Required: all outputs 0 asynchronously, no done. Then start with genome all right (32'h5555_5555) -> identical to the first test.

Source files
------------

// File: rtl/maze_walker.sv
// maze_walker: runs one genome of 2-bit moves across an 8x8 wall bitmap,
// one move per clock, and reports the final position and whether every move
// was legal. Moves: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).
// Optional build macro WALKER_GOAL_STOP_EN: a legal move into (7,7) ends the walk.
module maze_walker #(
  parameter int          N_MOVES = 16,
  parameter logic [63:0] MAZE    = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*N_MOVES-1:0] genome,
  output logic [3:0]           xFin,
  output logic [3:0]           yFin,
  output logic                 alive,
  output logic                 done,
  output logic                 busy
);

  localparam int GW = 2 * N_MOVES;
  localparam int SW = (N_MOVES > 1) ? $clog2(N_MOVES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   genome_q, genome_d;
  logic [3:0]      x_q, x_d;
  logic [3:0]      y_q, y_d;
  logic            alive_q, alive_d;
  logic [SW-1:0]   step_q, step_d;

  logic [1:0]      mv;
  logic [3:0]      tx, ty;
  logic            off_grid;
  logic            wall_hit;
  logic            last_move;

  // Target cell for the current move; off-grid shows up as 0-1=15 or 7+1=8
  always_comb begin
    mv       = genome_q[{step_q, 1'b0} +: 2];
    tx       = x_q;
    ty       = y_q;
    off_grid = 1'b0;
    case (mv)
      2'b00: begin
        ty       = y_q - 4'd1;
        off_grid = (ty == 4'd15);
      end
      2'b01: begin
        tx       = x_q + 4'd1;
        off_grid = (tx == 4'd8);
      end
      2'b10: begin
        ty       = y_q + 4'd1;
        off_grid = (ty == 4'd8);
      end
      default: begin
        tx       = x_q - 4'd1;
        off_grid = (tx == 4'd15);
      end
    endcase
    wall_hit = !off_grid && MAZE[{ty[2:0], tx[2:0]}];
  end

  // Next-state and datapath update for the walk FSM
  always_comb begin
    state_d   = state_q;
    genome_d  = genome_q;
    x_d       = x_q;
    y_d       = y_q;
    alive_d   = alive_q;
    step_d    = step_q;
    last_move = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          genome_d = genome;
          x_d      = '0;
          y_d      = '0;
          alive_d  = 1'b1;
          step_d   = '0;
          state_d  = WALK;
        end
      end
      WALK: begin
        if (off_grid || wall_hit) begin
          alive_d = 1'b0;
          state_d = DONE;
        end else begin
          x_d       = tx;
          y_d       = ty;
          last_move = (step_q == SW'(N_MOVES - 1));
`ifdef WALKER_GOAL_STOP_EN
          if (tx == 4'd7 && ty == 4'd7) last_move = 1'b1;
`endif
          if (last_move) state_d = DONE;
          else           step_d  = step_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      genome_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      alive_q  <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      genome_q <= genome_d;
      x_q      <= x_d;
      y_q      <= y_d;
      alive_q  <= alive_d;
      step_q   <= step_d;
    end
  end

  assign xFin  = x_q;
  assign yFin  = y_q;
  assign alive = alive_q;
  assign done  = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_maze_walker.sv
// Scoreboard bench for maze_walker: stimulus pushes expected results (position,
// alive, cycle at which done must appear), monitors pop on each done pulse.
module tb_maze_walker;

  localparam int N = 16;
  localparam logic [31:0] ALL_RIGHT = 32'h5555_5555;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       alive;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, start_w = 1'b0;
  logic [2*N-1:0] genome = '0, genome_w = '0;
  logic [3:0]    x_fin, y_fin, x_fin_w, y_fin_w;
  logic          alive, done, busy, alive_w, done_w, busy_w;

  exp_t q[$];
  exp_t qw[$];
  int   cyc = 0;
  int   asserts = 0;
  int   errors = 0;

  maze_walker #(.N_MOVES(N), .MAZE(64'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .genome(genome),
    .xFin(x_fin), .yFin(y_fin), .alive(alive), .done(done), .busy(busy)
  );

  maze_walker #(.N_MOVES(N), .MAZE(64'h2)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .genome(genome_w),
    .xFin(x_fin_w), .yFin(y_fin_w), .alive(alive_w), .done(done_w), .busy(busy_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int expv);
    asserts++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor for the open-maze instance
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xFin", int'(x_fin), int'(e.x));
        chk("yFin", int'(y_fin), int'(e.y));
        chk("alive", int'(alive), int'(e.alive));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for the walled-maze instance
  always @(negedge clk) begin
    if (!rst && done_w) begin
      if (qw.size() == 0) begin
        chk("unexpected_done_w", 1, 0);
      end else begin
        exp_t e;
        e = qw.pop_front();
        chk("xFin_w", int'(x_fin_w), int'(e.x));
        chk("yFin_w", int'(y_fin_w), int'(e.y));
        chk("alive_w", int'(alive_w), int'(e.alive));
        chk("done_cycle_w", cyc, e.cyc);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget && (q.size() != 0 || qw.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0 || qw.size() != 0) begin
      asserts++;
      errors++;
      $display("FAIL timeout: %0d/%0d results pending, required 0", q.size(), qw.size());
      q.delete();
      qw.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // One walk on the open maze; lat counts edges from the start-sampling edge (=1)
  task automatic run_walk(input logic [2*N-1:0] g, input logic [3:0] ex,
                          input logic [3:0] ey, input logic ea, input int lat);
    exp_t e;
    @(negedge clk);
    genome = g;
    start  = 1'b1;
    e.x = ex; e.y = ey; e.alive = ea; e.cyc = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
  endtask

  logic [2*N-1:0] path_g;
  int             busy_cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    exp_t e;
    // Reset state
    #12;
    chk("rst_xFin", int'(x_fin), 0);
    chk("rst_yFin", int'(y_fin), 0);
    chk("rst_alive", int'(alive), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // All right: dies at move 7 at (7,0)
    run_walk(ALL_RIGHT, 4'd7, 4'd0, 1'b0, 9);

    // Right x7, down x7, left x2
    path_g = '0;
    for (int i = 0; i < N; i++) begin
      if (i < 7)       path_g[2*i +: 2] = 2'b01;
      else if (i < 14) path_g[2*i +: 2] = 2'b10;
      else             path_g[2*i +: 2] = 2'b11;
    end
`ifdef WALKER_GOAL_STOP_EN
    run_walk(path_g, 4'd7, 4'd7, 1'b1, 15);
`else
    run_walk(path_g, 4'd5, 4'd7, 1'b1, 17);
`endif

    // Wall at (1,0): first move right hits it
    @(negedge clk);
    genome_w = ALL_RIGHT;
    start_w  = 1'b1;
    e.x = 4'd0; e.y = 4'd0; e.alive = 1'b0; e.cyc = cyc + 2;
    qw.push_back(e);
    @(negedge clk);
    start_w = 1'b0;
    wait_drain(40);

    // Move 0 up: immediate death, busy for exactly two cycles
    @(negedge clk);
    genome = '0;
    start  = 1'b1;
    e.x = 4'd0; e.y = 4'd0; e.alive = 1'b0; e.cyc = cyc + 2;
    q.push_back(e);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 2);
    wait_drain(40);

    // start pulses and genome changes mid-walk are ignored
    @(negedge clk);
    genome = ALL_RIGHT;
    start  = 1'b1;
    e.x = 4'd7; e.y = 4'd0; e.alive = 1'b0; e.cyc = cyc + 9;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    genome = '0;
    repeat (2) @(negedge clk);
    start  = 1'b0;
    genome = ALL_RIGHT;
    wait_drain(40);

    // start held high: second walk begins on the first IDLE cycle after DONE
    @(negedge clk);
    genome = '0;
    start  = 1'b1;
    e.x = 4'd0; e.y = 4'd0; e.alive = 1'b0; e.cyc = cyc + 2;
    q.push_back(e);
    e.cyc = cyc + 5;
    q.push_back(e);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_drain(40);

    // Reset at step 5 abandons the walk without a done pulse
    @(negedge clk);
    genome = ALL_RIGHT;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("live_xFin_step5", int'(x_fin), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_xFin", int'(x_fin), 0);
    chk("arst_yFin", int'(y_fin), 0);
    chk("arst_alive", int'(alive), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Same as the first walk after reset
    run_walk(ALL_RIGHT, 4'd7, 4'd0, 1'b0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
